// File: rtl/lift_pkg.sv
// lift_pkg: shared state encoding, floor typing and one-hot decode for the lift car plant
package lift_pkg;
   localparam int NUM_FLOORS_DEF = 8;
   localparam int FLOOR_W = $clog2(NUM_FLOORS_DEF);
   typedef enum logic [2:0] {IDLE, MOVE_UP, MOVE_DN, DOOR_OPENING, DOOR_OPEN, DOOR_CLOSING} state_e;
   typedef logic [FLOOR_W-1:0] floor_t;
   function automatic logic [NUM_FLOORS_DEF-1:0] floor_onehot(input floor_t f);
      return NUM_FLOORS_DEF'(1) << f;
   endfunction
endpackage

// File: rtl/lift_timer.sv
// lift_timer: loadable down-counter that parks at zero and flags it
module lift_timer #(
   parameter int W = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         zero_o
);
   logic [W-1:0] cnt_q;
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) cnt_q <= '0;
      else if (load_i) cnt_q <= load_val_i;
      else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
   assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/lift_car.sv
// lift_car: lift car and shaft plant with travel/door timing, door-motion interlock and sticky fault
module lift_car
   import lift_pkg::*;
#(
   parameter int NUM_FLOORS    = NUM_FLOORS_DEF,
   parameter int TRAVEL_CYCLES = 16,
   parameter int DOOR_CYCLES   = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          up_i,
   input  logic                          down_i,
   input  logic                          open_i,
   input  logic                          close_i,
   output logic [$clog2(NUM_FLOORS)-1:0] floor_o,
   output logic [NUM_FLOORS-1:0]         floor_onehot_o,
   output logic                          moving_o,
   output logic                          door_open_o,
   output logic                          door_closed_o,
   output logic                          fault_o
);
   localparam int FW = $clog2(NUM_FLOORS);
   localparam int CW = $clog2(TRAVEL_CYCLES > DOOR_CYCLES ? TRAVEL_CYCLES : DOOR_CYCLES);
   localparam logic [FW-1:0] TOP = FW'(NUM_FLOORS - 1);
   localparam logic [CW-1:0] T_LOAD = CW'(TRAVEL_CYCLES - 1);
   localparam logic [CW-1:0] D_LOAD = CW'(DOOR_CYCLES - 1);

   state_e          state_q, state_d;
   logic [FW-1:0]   floor_q, floor_d, step_floor;
   logic [NUM_FLOORS-1:0] floor_onehot_q;
   logic            moving_q, door_open_q, door_closed_q, fault_q, fault_d;
   logic            load, zero, dir_up, same_cmd, other_cmd, step_end, bad_idle;
   logic [CW-1:0]   load_val;

   lift_timer #(.W(CW)) u_timer (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .load_i    (load),
      .load_val_i(load_val),
      .zero_o    (zero)
   );

   assign dir_up     = (state_q == MOVE_UP);
   assign same_cmd   = dir_up ? up_i : down_i;
   assign other_cmd  = dir_up ? down_i : up_i;
   assign step_floor = dir_up ? floor_q + 1'b1 : floor_q - 1'b1;
   assign step_end   = dir_up ? (step_floor == TOP) : (step_floor == '0);
   assign bad_idle   = (up_i & down_i) | (open_i & close_i) | (open_i & (up_i | down_i)) |
                       (up_i & (floor_q == TOP)) | (down_i & (floor_q == '0));

   always_comb begin
      state_d  = state_q;
      floor_d  = floor_q;
      fault_d  = fault_q;
      load     = 1'b0;
      load_val = T_LOAD;
      unique case (state_q)
         IDLE: begin
            if (bad_idle) fault_d = 1'b1;
            else if (up_i | down_i) begin
               state_d = up_i ? MOVE_UP : MOVE_DN;
               load    = 1'b1;
            end else if (open_i) begin
               state_d  = DOOR_OPENING;
               load     = 1'b1;
               load_val = D_LOAD;
            end
         end
         MOVE_UP, MOVE_DN: begin
            if (other_cmd | open_i | close_i) fault_d = 1'b1;
            // the car only reacts to its command at a floor boundary
            if (zero) begin
               floor_d = step_floor;
               if (same_cmd && !step_end) load = 1'b1;
               else state_d = IDLE;
               if (same_cmd && step_end) fault_d = 1'b1;
            end
         end
         DOOR_OPENING: begin
            if (up_i | down_i) fault_d = 1'b1;
            if (zero) state_d = DOOR_OPEN;
         end
         DOOR_OPEN: begin
            if (up_i | down_i) fault_d = 1'b1;
            if (close_i && !open_i) begin
               state_d  = DOOR_CLOSING;
               load     = 1'b1;
               load_val = D_LOAD;
            end
         end
         DOOR_CLOSING: begin
            if (up_i | down_i) fault_d = 1'b1;
            if (open_i) begin
               state_d  = DOOR_OPENING;
               load     = 1'b1;
               load_val = D_LOAD;
            end else if (zero) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= IDLE;
         floor_q        <= '0;
         floor_onehot_q <= NUM_FLOORS'(1);
         moving_q       <= 1'b0;
         door_open_q    <= 1'b0;
         door_closed_q  <= 1'b1;
         fault_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         floor_q        <= floor_d;
         floor_onehot_q <= NUM_FLOORS'(floor_onehot(floor_t'(floor_d)));
         moving_q       <= (state_d == MOVE_UP) || (state_d == MOVE_DN);
         door_open_q    <= (state_d == DOOR_OPEN);
         door_closed_q  <= (state_d == IDLE) || (state_d == MOVE_UP) || (state_d == MOVE_DN);
         fault_q        <= fault_d;
      end
   end

   assign floor_o        = floor_q;
   assign floor_onehot_o = floor_onehot_q;
   assign moving_o       = moving_q;
   assign door_open_o    = door_open_q;
   assign door_closed_o  = door_closed_q;
   assign fault_o        = fault_q;
endmodule

// File: tb/tb_lift_car.sv
// tb_lift_car: directed self-checking bench for the lift car plant
module tb_lift_car;
   logic       clk = 1'b0;
   logic       rst_ni = 1'b0;
   logic       up_i = 1'b0, down_i = 1'b0, open_i = 1'b0, close_i = 1'b0;
   logic [2:0] floor_o;
   logic [7:0] floor_onehot_o;
   logic       moving_o, door_open_o, door_closed_o, fault_o;
   int         checks = 0;
   int         failures = 0;

   lift_car dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .up_i          (up_i),
      .down_i        (down_i),
      .open_i        (open_i),
      .close_i       (close_i),
      .floor_o       (floor_o),
      .floor_onehot_o(floor_onehot_o),
      .moving_o      (moving_o),
      .door_open_o   (door_open_o),
      .door_closed_o (door_closed_o),
      .fault_o       (fault_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_rst();
      #3 rst_ni = 1'b0;
      #1 rst_ni = 1'b1;
   endtask

   initial begin
      tick(2);
      chk("rst_floor", floor_o, 0);
      chk("rst_onehot", floor_onehot_o, 8'h01);
      chk("rst_moving", moving_o, 0);
      chk("rst_door_open", door_open_o, 0);
      chk("rst_door_closed", door_closed_o, 1);
      chk("rst_fault", fault_o, 0);
      rst_ni = 1'b1;
      // door open/close cycle
      open_i = 1'b1;
      tick(1);
      open_i = 1'b0;
      chk("open_closed_drop", door_closed_o, 0);
      tick(3);
      chk("open_not_yet", door_open_o, 0);
      tick(1);
      chk("open_done", door_open_o, 1);
      close_i = 1'b1;
      tick(1);
      close_i = 1'b0;
      chk("close_open_drop", door_open_o, 0);
      tick(3);
      chk("close_not_yet", door_closed_o, 0);
      tick(1);
      chk("close_done", door_closed_o, 1);
      chk("door_fault", fault_o, 0);
      // hold up for 40 cycles from G
      up_i = 1'b1;
      tick(1);
      chk("up_moving", moving_o, 1);
      tick(15);
      chk("up_f0_k15", floor_o, 0);
      tick(1);
      chk("up_f1_k16", floor_o, 1);
      chk("up_oh1", floor_onehot_o, 8'h02);
      tick(16);
      chk("up_f2_k32", floor_o, 2);
      tick(7);
      up_i = 1'b0;
      tick(8);
      chk("up_f2_k47", floor_o, 2);
      chk("up_mov_k47", moving_o, 1);
      tick(1);
      chk("up_f3_k48", floor_o, 3);
      chk("up_stop_k48", moving_o, 0);
      chk("up_oh3", floor_onehot_o, 8'h08);
      chk("up_fault", fault_o, 0);
      // travel 3 -> 7, release just before arrival
      up_i = 1'b1;
      tick(64);
      up_i = 1'b0;
      chk("top_f6", floor_o, 6);
      tick(1);
      chk("top_f7", floor_o, 7);
      chk("top_oh7", floor_onehot_o, 8'h80);
      chk("top_stop", moving_o, 0);
      chk("top_nofault", fault_o, 0);
      up_i = 1'b1;
      tick(1);
      chk("top_up_fault", fault_o, 1);
      tick(4);
      up_i = 1'b0;
      chk("top_stay_f7", floor_o, 7);
      chk("top_stay_mov", moving_o, 0);
      #3 rst_ni = 1'b0;
      #1;
      chk("arst_floor_top", floor_o, 0);
      chk("arst_fault", fault_o, 0);
      rst_ni = 1'b1;
      // arrive at G with down still held
      up_i = 1'b1;
      tick(1);
      up_i = 1'b0;
      tick(16);
      chk("g_f1", floor_o, 1);
      chk("g_f1_stop", moving_o, 0);
      down_i = 1'b1;
      tick(16);
      chk("g_f1_dn", floor_o, 1);
      chk("g_fault_pre", fault_o, 0);
      tick(1);
      chk("g_f0", floor_o, 0);
      chk("g_f0_stop", moving_o, 0);
      chk("g_end_fault", fault_o, 1);
      down_i = 1'b0;
      tick(3);
      chk("g_fault_sticky", fault_o, 1);
      pulse_rst();
      // door open + up, then safety reopen
      open_i = 1'b1;
      tick(1);
      open_i = 1'b0;
      tick(4);
      chk("il_open", door_open_o, 1);
      up_i = 1'b1;
      tick(1);
      chk("il_fault", fault_o, 1);
      chk("il_nomove", moving_o, 0);
      tick(3);
      up_i = 1'b0;
      chk("il_floor", floor_o, 0);
      chk("il_still_open", door_open_o, 1);
      close_i = 1'b1;
      tick(1);
      close_i = 1'b0;
      tick(1);
      open_i = 1'b1;
      tick(1);
      open_i = 1'b0;
      chk("ro_open_low", door_open_o, 0);
      tick(2);
      chk("ro_not_closed", door_closed_o, 0);
      tick(1);
      chk("ro_not_yet", door_open_o, 0);
      tick(1);
      chk("ro_open", door_open_o, 1);
      pulse_rst();
      // conflicts in IDLE
      up_i = 1'b1;
      down_i = 1'b1;
      tick(1);
      up_i = 1'b0;
      down_i = 1'b0;
      chk("ud_fault", fault_o, 1);
      chk("ud_mov", moving_o, 0);
      chk("ud_closed", door_closed_o, 1);
      pulse_rst();
      open_i = 1'b1;
      close_i = 1'b1;
      tick(1);
      open_i = 1'b0;
      close_i = 1'b0;
      chk("oc_fault", fault_o, 1);
      chk("oc_closed", door_closed_o, 1);
      pulse_rst();
      close_i = 1'b1;
      tick(1);
      close_i = 1'b0;
      chk("cl_nofault", fault_o, 0);
      chk("cl_closed", door_closed_o, 1);
      // reset mid-move
      up_i = 1'b1;
      tick(9);
      chk("mr_moving", moving_o, 1);
      #3 rst_ni = 1'b0;
      #1;
      up_i = 1'b0;
      chk("mr_floor", floor_o, 0);
      chk("mr_moving_rst", moving_o, 0);
      chk("mr_closed", door_closed_o, 1);
      rst_ni = 1'b1;
      tick(20);
      chk("mr_idle_floor", floor_o, 0);
      up_i = 1'b1;
      tick(1);
      up_i = 1'b0;
      chk("mr_resume_mov", moving_o, 1);
      tick(16);
      chk("mr_resume_f1", floor_o, 1);
      chk("mr_resume_stop", moving_o, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/lift_car.md
# lift_car

Cycle-based model of the lift car and shaft that sits on the far side of the `elevator` controller. It consumes the controller's `up`/`down`/`open`/`close` commands and returns car position and door status, with per-floor travel time and door timing. It enforces the door/motion interlock and flags illegal command patterns. It is used as the plant in closed-loop controller benches, and as the sensor and actuator front end in the FPGA demo.

## Interface
- `NUM_FLOORS`, 8: floors G..7. Index 0 = G.
- `TRAVEL_CYCLES`, 16: clock cycles to travel one floor. Must be ≥ 2.
- `DOOR_CYCLES`, 4: clock cycles for a full door open or close stroke. Must be ≥ 2.
- `clk` in 1: clock; all state changes on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `up` in 1: motor up command (level).
- `down` in 1: motor down command (level).
- `open` in 1: door open command (level).
- `close` in 1: door close command (level).
- `floor` out $clog2(NUM_FLOORS): current (last passed) floor index.
- `floor_onehot` out NUM_FLOORS: one-hot of `floor`; bit 0 = G.
- `moving` out 1: car is between floors or travelling.
- `door_open` out 1: door fully open.
- `door_closed` out 1: door fully closed.
- `fault` out 1: sticky illegal-command flag; cleared only by reset.

## Operation
- All outputs are registered.
- Reset values:
  - `floor`=0, `floor_onehot`=1, `moving`=0, `door_open`=0, `door_closed`=1, `fault`=0.
  - State = IDLE, and counter = 0.
- States: IDLE, MOVE_UP, MOVE_DN, DOOR_OPENING, DOOR_OPEN, DOOR_CLOSING.
- IDLE (door closed, stopped):
  - Conflicts (`up&down`, `open&close`, `open` together with `up`/`down`) → set `fault`, stay in IDLE.
  - `up` at top floor, or `down` at G → set `fault`, stay in IDLE.
  - `up` → MOVE_UP, load counter TRAVEL_CYCLES-1, `moving`=1.
  - `down` → MOVE_DN, load counter TRAVEL_CYCLES-1, `moving`=1.
  - `open` → DOOR_OPENING, load counter DOOR_CYCLES-1, `door_closed`=0.
  - `close` alone → no effect.
- MOVE_UP and MOVE_DN:
  - Counter decrements each cycle.
  - At counter==0, `floor` steps by ±1. The car cannot stop between floors, so dropping the command mid-span has effect only at the next boundary.
  - If the same command is still asserted and the new floor is not the end floor, reload the counter and continue.
  - Otherwise go to IDLE with `moving`=0.
  - Arriving at the end floor with the command still asserted → IDLE and set `fault`.
  - The opposite direction, `open`, or `close` while moving → set `fault`; the command is ignored.
- DOOR_OPENING:
  - At counter==0 → DOOR_OPEN, `door_open`=1.
  - `close` is ignored until the door is fully open.
  - `up`/`down` → set `fault`, ignored.
- DOOR_OPEN:
  - `close & !open` → DOOR_CLOSING, load DOOR_CYCLES-1, `door_open`=0.
  - `up`/`down` → set `fault`, ignored.
- DOOR_CLOSING:
  - `open` → safety reopen: DOOR_OPENING with a full reload of DOOR_CYCLES-1.
  - At counter==0 → IDLE, `door_closed`=1.
  - `up`/`down` → set `fault`, ignored.
- Counter width is $clog2(max(TRAVEL_CYCLES, DOOR_CYCLES)). `floor` never wraps; it saturates at 0 and NUM_FLOORS-1 by construction.

## Timing
- Command sampled at edge k:
  - The state and `moving`/`door_closed` change at edge k.
  - `floor` changes at edge k+TRAVEL_CYCLES.
  - `door_open` rises at edge k+DOOR_CYCLES.
- Continuous travel: one floor every TRAVEL_CYCLES cycles, with no idle gap.
- After arrival, a new command is accepted from the edge that enters IDLE plus one.
- Safety reopen sampled at edge j: `door_open` rises at j+DOOR_CYCLES.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronously). The position is lost and the car restarts at G.
- `fault` rises at the edge that samples the illegal pattern and holds until `rst` is low.

## Structure
- Package `lift_pkg` holds:
  - the state enum;
  - the default NUM_FLOORS;
  - the floor index typedef;
  - the one-hot decode function.
- Sub-module `lift_timer`: a loadable down-counter with a `zero` flag. One instance is shared between travel and door timing, since they are never active together.

## Test plan
- Reset, then `open` for 1 cycle → `door_closed`=0 next edge, `door_open`=1 after 4 cycles. Then `close` → `door_closed`=1 after 4 more cycles; `fault`=0.
- From G, hold `up` for 40 cycles then release → `floor` 1 at cycle 16, 2 at cycle 32, 3 at cycle 48, then `moving`=0 at `floor`=3.
- At `floor`=7, hold `up` → `fault`=1, `floor` stays 7, `moving`=0.
- Door open, assert `up` → `fault`=1 and the car does not move. Assert `close`, then `open` 2 cycles into the close stroke → DOOR_OPENING, `door_open`=1 after 4 cycles.
- Assert `up&down` in IDLE → `fault`=1 at the next edge, state unchanged.
- Drop `rst` at cycle 8 of an up move → `floor`=0, `moving`=0, `door_closed`=1 immediately. Normal operation resumes after `rst` goes high.
